ex_stage_mc: RTL

Parametrised, registered execute stage for the pipelined CPU. It selects forwarded operands, runs single-cycle ALU operations and iterative unsigned multiply/divide, and holds the result, store data and flags in an output register. Valid/ready handshakes on both sides let the hazard logic stall decode while a multi-cycle operation is in flight. It sits between the ID/EX register and the EX/MEM register.

---
 rtl/ex_stage_mc_if.sv | 45 ++++
 rtl/ex_stage_mc.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage_mc_if.sv
// Bundle between the ID/EX register, the execute stage and the EX/MEM register.
// Handshake rule for both sides: a transfer happens on a rising edge where
// valid && ready are both high; once valid is raised the producer holds it and
// its payload stable until that edge, and ready may depend combinationally on
// the consumer-side signals but never on valid.
interface ex_stage_mc_if #(
   parameter int XLEN = 32
);
   logic            flush;
   logic            in_valid;
   logic            in_ready;
   logic [4:0]      alu_op;
   logic [6:0]      op;
   logic            isForw_ON;
   logic [1:0]      forwA;
   logic [1:0]      forwB;
   logic [XLEN-1:0] exmem_result;
   logic [XLEN-1:0] memwb_result;
   logic [XLEN-1:0] data1;
   logic [XLEN-1:0] data2;
   logic [XLEN-1:0] s_data;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] result;
   logic [XLEN-1:0] sData;
   logic            Z;
   logic            N;
   logic            C;
   logic            V;
   logic            busy;

   // Pipeline / bench side: drives the operation and the downstream ready.
   modport master (
      output flush, in_valid, alu_op, op, isForw_ON, forwA, forwB,
             exmem_result, memwb_result, data1, data2, s_data, out_ready,
      input  in_ready, out_valid, result, sData, Z, N, C, V, busy
   );

   // Execute stage side.
   modport slave (
      input  flush, in_valid, alu_op, op, isForw_ON, forwA, forwB,
             exmem_result, memwb_result, data1, data2, s_data, out_ready,
      output in_ready, out_valid, result, sData, Z, N, C, V, busy
   );
endinterface

// File: rtl/ex_stage_mc.sv
// Registered execute stage: forwarding muxes, single-cycle ALU, and an
// iterative radix-2 unsigned multiplier/divider sharing one output register.
module ex_stage_mc #(
   parameter int XLEN  = 32,
   parameter int CNT_W = $clog2(XLEN) + 1
) (
   input  logic         clk,
   input  logic         rst_n,
   ex_stage_mc_if.slave bus,
   output logic [1:0]   dbg_state_o
);
   localparam int SH_W = $clog2(XLEN);

   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_ALUI  = 7'b0010011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;

   localparam logic [4:0] ALU_ADD  = 5'h00;
   localparam logic [4:0] ALU_SUB  = 5'h01;
   localparam logic [4:0] ALU_SLL  = 5'h02;
   localparam logic [4:0] ALU_SLT  = 5'h03;
   localparam logic [4:0] ALU_SLTU = 5'h04;
   localparam logic [4:0] ALU_XOR  = 5'h05;
   localparam logic [4:0] ALU_SRL  = 5'h06;
   localparam logic [4:0] ALU_SRA  = 5'h07;
   localparam logic [4:0] ALU_OR   = 5'h08;
   localparam logic [4:0] ALU_AND  = 5'h09;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ITER = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   // m_q: multiplicand (mul) or divisor (div); hi/lo: product or remainder/quotient pair
   logic [XLEN-1:0]   m_q, m_d;
   logic [XLEN-1:0]   hi_q, hi_d;
   logic [XLEN-1:0]   lo_q, lo_d;
   // mop_q[1] = divide, mop_q[0] = take the high half (MULHU / REMU)
   logic [1:0]        mop_q, mop_d;
   logic [XLEN-1:0]   result_q, result_d;
   logic [XLEN-1:0]   sdata_q, sdata_d;
   logic              z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d;
   logic              out_valid_q, out_valid_d;

   logic [XLEN-1:0]   op_a, op_b, st_data;
   logic              accept, is_multi;
   logic [XLEN:0]     add_w;
   logic [XLEN-1:0]   sub_w;
   logic [SH_W-1:0]   shamt;
   logic [XLEN-1:0]   alu_res;
   logic              alu_c, alu_v;
   logic [XLEN:0]     mul_sum, div_r;
   logic              div_ge;
   logic [XLEN-1:0]   step_hi, step_lo, fin_res;

   // 00 and 11 select the register file; forwarding off ignores the select.
   function automatic logic [XLEN-1:0] fwd_sel(
      input logic            en,
      input logic [1:0]      sel,
      input logic [XLEN-1:0] rf,
      input logic [XLEN-1:0] ex,
      input logic [XLEN-1:0] wb
   );
      logic [XLEN-1:0] val;
      val = rf;
      if (en) begin
         if (sel == 2'b01)      val = ex;
         else if (sel == 2'b10) val = wb;
      end
      return val;
   endfunction

   // A new operation is taken only from IDLE, when the output slot frees up this edge.
   assign bus.in_ready  = (state_q == S_IDLE) && (!out_valid_q || bus.out_ready) && !bus.flush;
   assign accept        = bus.in_valid && bus.in_ready;
   assign is_multi      = (bus.alu_op[4:2] == 3'b100);
   // The last ITER cycle (counter already 0) only writes the result, so it is not counted as busy.
   assign bus.busy      = (state_q == S_ITER) && (cnt_q != '0);
   assign bus.out_valid = out_valid_q;
   assign bus.result    = result_q;
   assign bus.sData     = sdata_q;
   assign bus.Z         = z_q;
   assign bus.N         = n_q;
   assign bus.C         = c_q;
   assign bus.V         = v_q;
   assign dbg_state_o   = state_q;

   // Operand and store-data selection; loads, ALU-immediates and stores use B unforwarded.
   always_comb begin
      op_a = fwd_sel(bus.isForw_ON, bus.forwA, bus.data1, bus.exmem_result, bus.memwb_result);
      op_b = fwd_sel(bus.isForw_ON, bus.forwB, bus.data2, bus.exmem_result, bus.memwb_result);
      if (bus.op == OPC_LOAD || bus.op == OPC_ALUI || bus.op == OPC_STORE) begin
         op_b = bus.data2;
      end
      st_data = bus.s_data;
      if (bus.op == OPC_STORE) begin
         st_data = fwd_sel(bus.isForw_ON, bus.forwB, bus.s_data, bus.exmem_result, bus.memwb_result);
      end
   end

   // Single-cycle ALU with carry/overflow for ADD and SUB only.
   always_comb begin
      add_w   = {1'b0, op_a} + {1'b0, op_b};
      sub_w   = op_a - op_b;
      shamt   = op_b[SH_W-1:0];
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (bus.alu_op)
         ALU_ADD: begin
            alu_res = add_w[XLEN-1:0];
            alu_c   = add_w[XLEN];
            alu_v   = (op_a[XLEN-1] == op_b[XLEN-1]) && (add_w[XLEN-1] != op_a[XLEN-1]);
         end
         ALU_SUB: begin
            alu_res = sub_w;
            alu_c   = (op_a >= op_b);
            alu_v   = (op_a[XLEN-1] != op_b[XLEN-1]) && (sub_w[XLEN-1] != op_a[XLEN-1]);
         end
         ALU_SLL:  alu_res = op_a << shamt;
         ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
         ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
         ALU_XOR:  alu_res = op_a ^ op_b;
         ALU_SRL:  alu_res = op_a >> shamt;
         ALU_SRA:  alu_res = $signed(op_a) >>> shamt;
         ALU_OR:   alu_res = op_a | op_b;
         ALU_AND:  alu_res = op_a & op_b;
         default:  alu_res = '0;
      endcase
   end

   // One radix-2 step: shift-add multiply (right shift) or restoring divide (left shift).
   always_comb begin
      mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
      div_r   = {hi_q, lo_q[XLEN-1]};
      div_ge  = (div_r >= {1'b0, m_q});
      if (mop_q[1]) begin
         // A zero divisor always "fits": quotient becomes all ones, remainder becomes A.
         step_hi = div_ge ? (div_r[XLEN-1:0] - m_q) : div_r[XLEN-1:0];
         step_lo = {lo_q[XLEN-2:0], div_ge};
      end else begin
         step_hi = mul_sum[XLEN:1];
         step_lo = {mul_sum[0], lo_q[XLEN-1:1]};
      end
      fin_res = mop_q[0] ? hi_q : lo_q;
   end

   // Next-state logic for the FSM, the iteration registers and the output register.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      m_d         = m_q;
      hi_d        = hi_q;
      lo_d        = lo_q;
      mop_d       = mop_q;
      result_d    = result_q;
      sdata_d     = sdata_q;
      z_d         = z_q;
      n_d         = n_q;
      c_d         = c_q;
      v_d         = v_q;
      out_valid_d = out_valid_q;
      if (out_valid_q && bus.out_ready) begin
         out_valid_d = 1'b0;
      end
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               sdata_d = st_data;
               if (is_multi) begin
                  m_d     = bus.alu_op[1] ? op_b : op_a;
                  lo_d    = bus.alu_op[1] ? op_a : op_b;
                  hi_d    = '0;
                  mop_d   = bus.alu_op[1:0];
                  cnt_d   = CNT_W'(XLEN);
                  state_d = S_ITER;
               end else begin
                  result_d    = alu_res;
                  z_d         = (alu_res == '0);
                  n_d         = alu_res[XLEN-1];
                  c_d         = alu_c;
                  v_d         = alu_v;
                  out_valid_d = 1'b1;
               end
            end
         end
         S_ITER: begin
            if (cnt_q != '0) begin
               hi_d  = step_hi;
               lo_d  = step_lo;
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               result_d    = fin_res;
               z_d         = (fin_res == '0);
               n_d         = fin_res[XLEN-1];
               c_d         = 1'b0;
               v_d         = 1'b0;
               out_valid_d = 1'b1;
               state_d     = S_DONE;
            end
         end
         S_DONE: begin
            if (bus.out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // Flush kills both the iterating and the held operation; data registers may stay stale.
      if (bus.flush) begin
         state_d     = S_IDLE;
         out_valid_d = 1'b0;
         cnt_d       = '0;
      end
   end

   // State and datapath registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         m_q         <= '0;
         hi_q        <= '0;
         lo_q        <= '0;
         mop_q       <= '0;
         result_q    <= '0;
         sdata_q     <= '0;
         z_q         <= 1'b0;
         n_q         <= 1'b0;
         c_q         <= 1'b0;
         v_q         <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         m_q         <= m_d;
         hi_q        <= hi_d;
         lo_q        <= lo_d;
         mop_q       <= mop_d;
         result_q    <= result_d;
         sdata_q     <= sdata_d;
         z_q         <= z_d;
         n_q         <= n_d;
         c_q         <= c_d;
         v_q         <= v_d;
         out_valid_q <= out_valid_d;
      end
   end
endmodule
